// File: rtl/spi_ram_master.sv
// Master sequencer for the single-clock SPI RAM slave.
// Each one-byte request is sent as two 10-bit command frames.
// Opcode 00 carries the write address and 01 carries the write data.
// Opcode 10 carries the read address and 11 carries a dummy byte while the
// master captures eight MISO bits. Frames are sent MSB first, one bit per clk.
module spi_ram_master #(
    parameter int ADDR_W  = 8,
    parameter int TAIL    = 2,
    parameter int RD_WAIT = 4,
    parameter int GAP     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    typedef enum logic [2:0] {
        IDLE, SEL, SHIFT, TAIL_ST, RDWAIT, CAPTURE, GAP_ST
    } state_t;

    localparam logic [3:0] TAIL_LAST = 4'(TAIL - 1);
    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

    state_t      state, state_nxt;
    logic [9:0]  word, word_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        second, second_nxt;
    logic        is_wr, is_wr_nxt;
    logic [7:0]  wdata_q, wdata_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        ss_n_nxt, mosi_nxt, ready_nxt, busy_nxt, rsp_valid_nxt;
    logic [7:0]  rdata_nxt;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt     = state;
        word_nxt      = word;
        cnt_nxt       = cnt;
        second_nxt    = second;
        is_wr_nxt     = is_wr;
        wdata_nxt     = wdata_q;
        shreg_nxt     = shreg;
        ss_n_nxt      = 1'b1;
        mosi_nxt      = 1'b0;
        ready_nxt     = 1'b0;
        busy_nxt      = 1'b1;
        rsp_valid_nxt = 1'b0;
        rdata_nxt     = rsp_rdata;

        case (state)
            IDLE: begin
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    is_wr_nxt  = req_wr;
                    wdata_nxt  = req_wdata;
                    word_nxt   = {(req_wr ? 2'b00 : 2'b10), req_addr};
                    second_nxt = 1'b0;
                    state_nxt  = SEL;
                    ss_n_nxt   = 1'b0;
                    mosi_nxt   = word_nxt[9];
                    busy_nxt   = 1'b1;
                    ready_nxt  = 1'b0;
                end
            end
            SEL: begin
                // The slave peeks at the command-type bit here, so it is
                // presented once before the full ten-bit shift.
                ss_n_nxt  = 1'b0;
                mosi_nxt  = word[9];
                cnt_nxt   = 4'd9;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                ss_n_nxt = 1'b0;
                if (cnt == 4'd0) begin
                    if (word[9:8] == 2'b11) begin
                        state_nxt = RDWAIT;
                        cnt_nxt   = WAIT_LAST;
                    end else begin
                        state_nxt = TAIL_ST;
                        cnt_nxt   = TAIL_LAST;
                    end
                end else begin
                    cnt_nxt  = cnt - 4'd1;
                    mosi_nxt = word[cnt - 4'd1];
                end
            end
            TAIL_ST: begin
                if (cnt == 4'd0) begin
                    state_nxt = GAP_ST;
                    cnt_nxt   = GAP_LAST;
                end else begin
                    ss_n_nxt = 1'b0;
                    cnt_nxt  = cnt - 4'd1;
                end
            end
            RDWAIT: begin
                ss_n_nxt = 1'b0;
                if (cnt == 4'd0) begin
                    state_nxt = CAPTURE;
                    cnt_nxt   = 4'd7;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            CAPTURE: begin
                shreg_nxt = {shreg[6:0], MISO};
                if (cnt == 4'd0) begin
                    rdata_nxt     = {shreg[6:0], MISO};
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = GAP_ST;
                    cnt_nxt       = GAP_LAST;
                end else begin
                    ss_n_nxt = 1'b0;
                    cnt_nxt  = cnt - 4'd1;
                end
            end
            GAP_ST: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else if (!second) begin
                    second_nxt = 1'b1;
                    word_nxt   = is_wr ? {2'b01, wdata_q} : {2'b11, 8'h00};
                    state_nxt  = SEL;
                    ss_n_nxt   = 1'b0;
                    mosi_nxt   = word_nxt[9];
                end else begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state and pin outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            second    <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            second    <= second_nxt;
            SS_n      <= ss_n_nxt;
            MOSI      <= mosi_nxt;
            req_ready <= ready_nxt;
            busy      <= busy_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rdata_nxt;
        end
    end

    // Request fields, frame word and capture shifter need no reset.
    always_ff @(posedge clk) begin
        word    <= word_nxt;
        is_wr   <= is_wr_nxt;
        wdata_q <= wdata_nxt;
        shreg   <= shreg_nxt;
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: a behavioural SPI RAM slave decodes the frames the
// master sends and answers reads. A byte-array reference model predicts read
// data, frame contents, frame lengths and operation latency.
module tb_spi_ram_master;

    localparam int TAIL     = 2;
    localparam int RD_WAIT  = 4;
    localparam int GAP      = 2;
    localparam int WR_LEN   = 1 + 10 + TAIL;
    localparam int RD_LEN   = 1 + 10 + RD_WAIT + 8;
    localparam int WR_BUSY  = 2 * (11 + TAIL + GAP);
    localparam int RD_BUSY  = (11 + TAIL + GAP) + (19 + RD_WAIT + GAP);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wr = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mram [256];
    logic [7:0] sram [256];
    logic [9:0] expw_q [$];
    int         expl_q [$];
    logic [7:0] last_rd;

    int         scnt = 0;
    logic [9:0] sword;
    logic       ssel;
    logic [7:0] s_wa, s_ra, s_byte;

    spi_ram_master #(.ADDR_W(8), .TAIL(TAIL), .RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Slave side: frame decode plus RAM model answering opcode-11 frames.
    task automatic frame_end();
        logic [9:0] ew;
        int         el;
        if (expw_q.size() == 0) begin
            chk("frame_extra", scnt, 0);
        end else begin
            ew = expw_q.pop_front();
            el = expl_q.pop_front();
            chk("frame_word", {22'd0, sword}, {22'd0, ew});
            chk("frame_sel", {31'd0, ssel}, {31'd0, ew[9]});
            chk("frame_len", scnt, el);
        end
        case (sword[9:8])
            2'b00: s_wa = sword[7:0];
            2'b01: sram[s_wa] = sword[7:0];
            2'b10: s_ra = sword[7:0];
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (rst) begin
            scnt = 0;
            MISO = 1'b0;
        end else if (!SS_n) begin
            if (scnt == 0) ssel = MOSI;
            else if (scnt <= 10) sword = {sword[8:0], MOSI};
            if (scnt >= 15 && scnt <= 22 && sword[9:8] == 2'b11) begin
                s_byte = sram[s_ra];
                MISO = s_byte[22 - scnt];
            end else begin
                MISO = 1'b0;
            end
            scnt++;
        end else begin
            chk("mosi_idle", {31'd0, MOSI}, 32'd0);
            if (scnt != 0) frame_end();
            scnt = 0;
            MISO = 1'b0;
        end
    end

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                         input logic keep, output int waited, output logic [7:0] exp_rd);
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        req_valid = 1'b1;
        waited    = 0;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            $display("FAIL accept_timeout: req_ready got 0 expected 1");
            $fatal(1, "request never accepted");
        end
        @(posedge clk);
        #1;
        if (wr) begin
            mram[addr] = data;
            expw_q.push_back({2'b00, addr}); expl_q.push_back(WR_LEN);
            expw_q.push_back({2'b01, data}); expl_q.push_back(WR_LEN);
        end else begin
            expw_q.push_back({2'b10, addr}); expl_q.push_back(WR_LEN);
            expw_q.push_back({2'b11, 8'h00}); expl_q.push_back(RD_LEN);
        end
        exp_rd = mram[addr];
        if (keep) begin
            req_wr    = 1'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic finish(input logic wr, input logic [7:0] exp_rd);
        int         nb = 0;
        int         np = 0;
        logic [7:0] got = 8'hxx;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                np++;
                got = rsp_rdata;
            end
            if (!busy) break;
            nb++;
            chk("ready_busy", {31'd0, req_ready}, 32'd0);
        end
        chk("busy_cycles", nb, wr ? WR_BUSY : RD_BUSY);
        chk("rsp_pulses", np, wr ? 0 : 1);
        if (!wr) begin
            chk("rdata", {24'd0, got}, {24'd0, exp_rd});
            last_rd = exp_rd;
        end
        chk("rdata_hold", {24'd0, rsp_rdata}, {24'd0, last_rd});
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic op(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        int         w;
        logic [7:0] e;
        issue(wr, addr, data, 1'b0, w, e);
        finish(wr, e);
    endtask

    initial begin
        int         w;
        logic [7:0] e;
        logic       prev_keep;
        logic       wr, keep;
        logic [7:0] addr, data;

        for (int i = 0; i < 256; i++) begin
            mram[i] = 8'h00;
            sram[i] = 8'h00;
        end
        last_rd = 8'h00;

        // reset held three cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ssn", {31'd0, SS_n}, 32'd1);
        chk("rst_mosi", {31'd0, MOSI}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);

        // single write, then read back
        op(1'b1, 8'h3C, 8'hA5);
        chk("ram_3c", {24'd0, sram[8'h3C]}, 32'hA5);
        op(1'b0, 8'h3C, 8'h00);
        chk("read_3c", {24'd0, rsp_rdata}, 32'hA5);

        // boundary addresses and data
        op(1'b1, 8'hFF, 8'hFF);
        op(1'b1, 8'h00, 8'h01);
        op(1'b0, 8'hFF, 8'h00);
        chk("read_ff", {24'd0, rsp_rdata}, 32'hFF);
        op(1'b0, 8'h00, 8'h00);
        chk("read_00", {24'd0, rsp_rdata}, 32'h01);

        // req_valid held high across three reads
        issue(1'b0, 8'hFF, 8'h00, 1'b1, w, e);
        finish(1'b0, e);
        issue(1'b0, 8'h00, 8'h00, 1'b1, w, e);
        chk("b2b_accept", w, 0);
        finish(1'b0, e);
        issue(1'b0, 8'h3C, 8'h00, 1'b0, w, e);
        chk("b2b_accept", w, 0);
        finish(1'b0, e);

        // reset during CAPTURE of a read
        issue(1'b0, 8'h3C, 8'h00, 1'b0, w, e);
        repeat (33) @(negedge clk);
        chk("mid_capture_ssn", {31'd0, SS_n}, 32'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_ssn", {31'd0, SS_n}, 32'd1);
        chk("abort_mosi", {31'd0, MOSI}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        expw_q.delete();
        expl_q.delete();
        last_rd = 8'h00;
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("abort_idle_ssn", {31'd0, SS_n}, 32'd1);
        end
        op(1'b1, 8'h10, 8'h5A);
        op(1'b0, 8'h10, 8'h00);
        chk("read_10", {24'd0, rsp_rdata}, 32'h5A);

        // randomized traffic
        prev_keep = 1'b0;
        for (int k = 0; k < 60; k++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            data = 8'($urandom);
            keep = (k < 59) && ($urandom_range(0, 2) == 0);
            if (!prev_keep) repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(wr, addr, data, keep, w, e);
            if (prev_keep) chk("b2b_accept", w, 0);
            finish(wr, e);
            prev_keep = keep;
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("frames_left", expw_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
